// File: rtl/song_writer_pkg.sv
// Shared definitions for the song recorder and the regfile song reader:
// word layout, special words and the recorder FSM state encoding.
package song_writer_pkg;

  // Song word layout: {band[11:9], note[8:5], duration[4:0]}
  localparam int BAND_W   = 3;
  localparam int NOTE_W   = 4;
  localparam int DUR_W    = 5;
  localparam int CODE_W   = BAND_W + NOTE_W;
  localparam int WORD_W   = CODE_W + DUR_W;
  localparam int DUR_LSB  = 0;
  localparam int NOTE_LSB = DUR_LSB + DUR_W;
  localparam int BAND_LSB = NOTE_LSB + NOTE_W;

  // A rest is encoded as band 7 / note 0, a band no real note can use.
  localparam logic [BAND_W-1:0] REST_BAND = 3'h7;

  // Duration 0 never occurs in a real entry, so the all-zero word marks the end.
  localparam logic [WORD_W-1:0] END_WORD = 12'h000;

  // {band, note} pair as sampled on a beat tick
  typedef logic [CODE_W-1:0] code_t;
  typedef logic [DUR_W-1:0]  dur_t;

  localparam code_t REST_CODE = {REST_BAND, {NOTE_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REC   = 2'd1,
    FLUSH = 2'd2,
    TERM  = 2'd3
  } sw_state_e;

  // Lowest set switch selects the note; no switch pressed means a rest.
  function automatic code_t encode_note(input logic [15:0] sw,
                                        input logic [BAND_W-1:0] band);
    code_t c;
    c = REST_CODE;
    // Scan from the top down so the lowest set bit is the last to win.
    for (int i = 15; i >= 0; i--) begin
      if (sw[i]) c = {band, NOTE_W'(i)};
    end
    return c;
  endfunction

  function automatic logic [WORD_W-1:0] pack_word(input code_t c, input dur_t len);
    return {c, len};
  endfunction

endpackage

// File: rtl/song_writer_if.sv
// Regfile write port c as driven by the song recorder.
//
// Handshake: wen_c is a one-cycle valid strobe with no ready; the regfile
// accepts a write on every cycle, so addr_c/data_c are meaningful only in
// cycles where wen_c=1 and at most one word is written per cycle.
interface song_writer_if;
  logic [15:0] addr_c;
  logic [11:0] data_c;
  logic        wen_c;

  modport master (output addr_c, output data_c, output wen_c);
  modport slave  (input  addr_c, input  data_c, input  wen_c);
endinterface

// File: rtl/song_writer_beat_gen.sv
// Beat tick generator: counts clk cycles while enabled and pulses tick on
// the last cycle of each beat period, then wraps back to zero.
module song_writer_beat_gen #(
  parameter int BEAT_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEAT_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear has priority, otherwise count up and wrap on tick.
  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/song_writer.sv
// Song recorder: samples keys and octave band once per beat while recording,
// run-length encodes them into song words, writes them through regfile
// port c and terminates the take with an END word.
module song_writer
  import song_writer_pkg::*;
#(
  parameter int          BEAT_DIV  = 12_500_000,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          DEPTH     = 64,
  parameter int          MAX_DUR   = 31
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          writing,
  input  logic          start,
  input  logic [15:0]   SW,
  input  logic [2:0]    band,
  song_writer_if.master wr,
  output logic          recording,
  output logic          full,
  output logic [15:0]   count,
  output sw_state_e     dbg_state
);

  // The last REC write may land here; the slot after it is kept for END.
  localparam logic [15:0] CAP_ADDR = BASE_ADDR + 16'(DEPTH - 2);
  localparam dur_t        MAX_LEN  = DUR_W'(MAX_DUR);

  sw_state_e   state_q, state_d;
  logic [15:0] ptr_q, ptr_d;       // next free address in the take
  logic [15:0] addr_q, addr_d;     // registered write address output
  logic [11:0] data_q, data_d;
  logic        wen_q, wen_d;
  logic        rec_q, rec_d;
  logic        full_q, full_d;
  logic [15:0] count_q, count_d;
  code_t       cur_q, cur_d;       // code of the run being accumulated
  dur_t        len_q, len_d;       // beats in that run, 0 = no run open

  logic        tick;
  logic        beat_run;
  code_t       code;
  logic        stop_req;
  logic        wr_req;
  logic [11:0] wr_word;

  assign beat_run = (state_q == REC);

  // Beat counter runs only while recording and restarts on every entry to REC.
  song_writer_beat_gen #(
    .BEAT_DIV (BEAT_DIV)
  ) u_beat_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!beat_run),
    .en    (beat_run),
    .tick  (tick)
  );

  // Next-state, run-length encoding and write-port request logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wen_d    = 1'b0;
    full_d   = full_q;
    count_d  = count_q;
    cur_d    = cur_q;
    len_d    = len_q;
    wr_req   = 1'b0;
    wr_word  = END_WORD;
    code     = encode_note(SW, band);
    stop_req = start || !writing;

    unique case (state_q)
      IDLE: begin
        // start is only honoured while the controller is in writing mode
        if (start && writing) begin
          state_d = REC;
          ptr_d   = BASE_ADDR;
          len_d   = '0;
          full_d  = 1'b0;
          count_d = '0;
        end
      end

      REC: begin
        if (tick) begin
          if (len_q == '0) begin
            // Leading rests are dropped; the first note opens the first run.
            if (code != REST_CODE) begin
              cur_d = code;
              len_d = dur_t'(1);
            end
          end else if ((code == cur_q) && (len_q < MAX_LEN)) begin
            len_d = len_q + dur_t'(1);
          end else begin
            // Run ended (new code or saturated): emit it and open a new run.
            wr_req  = 1'b1;
            wr_word = pack_word(cur_q, len_q);
            cur_d   = code;
            len_d   = dur_t'(1);
            if (ptr_q == CAP_ADDR) begin
              // Memory is full: drop the run just opened and go write END.
              full_d  = 1'b1;
              len_d   = '0;
              state_d = TERM;
            end
          end
        end
        // A tick in the stop cycle is handled above before leaving REC.
        if (stop_req && (state_d == REC)) begin
          state_d = FLUSH;
        end
      end

      FLUSH: begin
        if (len_q != '0) begin
          wr_req  = 1'b1;
          wr_word = pack_word(cur_q, len_q);
        end
        len_d   = '0;
        state_d = TERM;
      end

      TERM: begin
        wr_req  = 1'b1;
        wr_word = END_WORD;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Single shared write path so at most one word leaves per cycle.
    if (wr_req) begin
      wen_d   = 1'b1;
      addr_d  = ptr_q;
      data_d  = wr_word;
      ptr_d   = ptr_q + 16'd1;
      count_d = count_q + 16'd1;
    end

    rec_d = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= BASE_ADDR;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
      wen_q   <= 1'b0;
      rec_q   <= 1'b0;
      full_q  <= 1'b0;
      count_q <= '0;
      cur_q   <= REST_CODE;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wen_q   <= wen_d;
      rec_q   <= rec_d;
      full_q  <= full_d;
      count_q <= count_d;
      cur_q   <= cur_d;
      len_q   <= len_d;
    end
  end

  assign wr.addr_c = addr_q;
  assign wr.data_c = data_q;
  assign wr.wen_c  = wen_q;
  assign recording = rec_q;
  assign full      = full_q;
  assign count     = count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_song_writer.sv
// Bench for song_writer: two recorders (64-deep at base 0, 4-deep at base
// 0x100) share stimulus; expected writes come from a per-take run-length
// model of the played beats.
module tb_song_writer;
  import song_writer_pkg::*;

  localparam int          BEAT_DIV = 4;
  localparam int          MAX_DUR  = 31;
  localparam int          DEPTH_A  = 64;
  localparam int          DEPTH_B  = 4;
  localparam logic [15:0] BASE_A   = 16'h0000;
  localparam logic [15:0] BASE_B   = 16'h0100;
  localparam logic [6:0]  REST7    = 7'h70;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        writing;
  logic        start_a;
  logic        start_b;
  logic [15:0] sw;
  logic [2:0]  band;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  song_writer_if if_a ();
  song_writer_if if_b ();
  logic        rec_a, rec_b, full_a, full_b;
  logic [15:0] count_a, count_b;
  sw_state_e   st_a, st_b;

  song_writer #(.BEAT_DIV(BEAT_DIV), .BASE_ADDR(BASE_A), .DEPTH(DEPTH_A), .MAX_DUR(MAX_DUR)) dut_a (
    .clk(clk), .rst_n(rst_n), .writing(writing), .start(start_a), .SW(sw), .band(band),
    .wr(if_a), .recording(rec_a), .full(full_a), .count(count_a), .dbg_state(st_a));

  song_writer #(.BEAT_DIV(BEAT_DIV), .BASE_ADDR(BASE_B), .DEPTH(DEPTH_B), .MAX_DUR(MAX_DUR)) dut_b (
    .clk(clk), .rst_n(rst_n), .writing(writing), .start(start_b), .SW(sw), .band(band),
    .wr(if_b), .recording(rec_b), .full(full_b), .count(count_b), .dbg_state(st_b));

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  bit          quiet = 1'b0;
  logic [27:0] exp_q_a[$];
  logic [27:0] exp_q_b[$];
  int          wcyc_a[$];
  logic [15:0] beat_sw[$];
  logic [2:0]  beat_band[$];
  logic [11:0] model_words[$];
  bit          model_full;
  int          exp_cnt_a, exp_cnt_b;
  bit          exp_full_a, exp_full_b;
  bit          trunc_b;
  int          stop_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [6:0] ref_code(input logic [15:0] s, input logic [2:0] b);
    if (s == 16'h0000) return REST7;
    for (int i = 0; i < 16; i++) begin
      if (s[i]) return {b, 4'(i)};
    end
    return REST7;
  endfunction

  // Words a take of beat_sw/beat_band must leave in a memory of given depth.
  function automatic void run_model(input int depth);
    logic [6:0] ch_code[$];
    int         ch_len[$];
    bit         started;
    logic [6:0] c;
    int         keep;
    model_words.delete();
    started = 1'b0;
    for (int i = 0; i < beat_sw.size(); i++) begin
      c = ref_code(beat_sw[i], beat_band[i]);
      if (!started && c == REST7) continue;
      started = 1'b1;
      if (ch_code.size() > 0 && ch_code[ch_code.size()-1] == c && ch_len[ch_len.size()-1] < MAX_DUR)
        ch_len[ch_len.size()-1] = ch_len[ch_len.size()-1] + 1;
      else begin
        ch_code.push_back(c);
        ch_len.push_back(1);
      end
    end
    // Every run but the last is written while recording; the one that would
    // occupy the slot before END stops the take and discards the rest.
    keep = ch_code.size();
    model_full = 1'b0;
    if (keep > 0 && keep - 1 >= depth - 1) begin
      keep = depth - 1;
      model_full = 1'b1;
    end
    for (int k = 0; k < keep; k++) model_words.push_back({ch_code[k], 5'(ch_len[k])});
    model_words.push_back(12'h000);
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n && !quiet) begin
      if (if_a.wen_c) begin
        wcyc_a.push_back(cyc);
        if (exp_q_a.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL a_write: unexpected write addr %h data %h, none required", if_a.addr_c, if_a.data_c);
        end else begin
          check("a_write", {4'h0, if_a.addr_c, if_a.data_c}, {4'h0, exp_q_a.pop_front()});
        end
      end
      if (if_b.wen_c) begin
        if (exp_q_b.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL b_write: unexpected write addr %h data %h, none required", if_b.addr_c, if_b.data_c);
        end else begin
          check("b_write", {4'h0, if_b.addr_c, if_b.data_c}, {4'h0, exp_q_b.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pin(input string name, input int depth, input int n, input bit f,
                     input logic [11:0] w0, input logic [11:0] w1, input logic [11:0] w2);
    run_model(depth);
    check({name, "_len"}, model_words.size(), n);
    check({name, "_full"}, model_full, f);
    if (model_words.size() > 0) check({name, "_w0"}, model_words[0], w0);
    if (model_words.size() > 1) check({name, "_w1"}, model_words[1], w1);
    if (model_words.size() > 2) check({name, "_w2"}, model_words[2], w2);
  endtask

  // stop_mode: 0 = start pulse after the last beat, 1 = start pulse on the
  // last beat's tick, 2 = writing drops after the last beat.
  task automatic run_take(input int stop_mode);
    exp_q_a.delete(); exp_q_b.delete(); wcyc_a.delete();
    run_model(DEPTH_A);
    for (int k = 0; k < model_words.size(); k++) exp_q_a.push_back({BASE_A + 16'(k), model_words[k]});
    exp_cnt_a = model_words.size(); exp_full_a = model_full;
    run_model(DEPTH_B);
    for (int k = 0; k < model_words.size(); k++) exp_q_b.push_back({BASE_B + 16'(k), model_words[k]});
    exp_cnt_b = model_words.size(); exp_full_b = model_full; trunc_b = model_full;

    @(negedge clk); start_a = 1'b1; start_b = 1'b1;
    @(negedge clk); start_a = 1'b0; start_b = 1'b0;
    for (int i = 0; i < beat_sw.size(); i++) begin
      sw = beat_sw[i]; band = beat_band[i];
      if (i == beat_sw.size() - 1 && stop_mode == 1) begin
        repeat (BEAT_DIV - 1) @(negedge clk);
        start_a = 1'b1; start_b = !trunc_b;
        @(negedge clk);
        stop_cyc = cyc;
        start_a = 1'b0; start_b = 1'b0;
      end else begin
        repeat (BEAT_DIV) @(negedge clk);
      end
    end
    if (stop_mode == 0) begin
      start_a = 1'b1; start_b = !trunc_b;
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
    end else if (stop_mode == 2) begin
      writing = 1'b0;
      repeat (2) @(negedge clk);
      writing = 1'b1;
    end
    sw = 16'h0000;
    repeat (6) @(negedge clk);
    check("a_pending", exp_q_a.size(), 0);
    check("b_pending", exp_q_b.size(), 0);
    check("a_count", count_a, exp_cnt_a);
    check("b_count", count_b, exp_cnt_b);
    check("a_full", full_a, exp_full_a);
    check("b_full", full_b, exp_full_b);
    check("a_recording", rec_a, 0);
    check("b_recording", rec_b, 0);
    check("a_state", 32'(st_a), 32'(IDLE));
    check("b_state", 32'(st_b), 32'(IDLE));
  endtask

  task automatic set_beats(input logic [15:0] s, input logic [2:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      beat_sw.push_back(s); beat_band.push_back(b);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_addr"}, if_a.addr_c, BASE_A);
    check({tag, "_b_addr"}, if_b.addr_c, BASE_B);
    check({tag, "_a_data"}, if_a.data_c, 0);
    check({tag, "_a_wen"}, if_a.wen_c, 0);
    check({tag, "_b_wen"}, if_b.wen_c, 0);
    check({tag, "_a_rec"}, rec_a, 0);
    check({tag, "_b_full"}, full_b, 0);
    check({tag, "_a_count"}, count_a, 0);
    check({tag, "_b_count"}, count_b, 0);
    check({tag, "_a_state"}, 32'(st_a), 32'(IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          mode;
    int          nb;
    int          r;
    logic [15:0] s;
    logic [2:0]  b;

    rst_n = 1'b0; writing = 1'b0; start_a = 1'b0; start_b = 1'b0; sw = '0; band = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1; writing = 1'b1;
    @(negedge clk);

    // Basic take
    beat_sw.delete(); beat_band.delete();
    set_beats(16'h0004, 3'd2, 3); set_beats(16'h0001, 3'd2, 2);
    pin("basic_model", DEPTH_A, 3, 1'b0, 12'h443, 12'h402, 12'h000);
    run_take(0);

    // Leading rests and a rest run
    beat_sw.delete(); beat_band.delete();
    set_beats(16'h0000, 3'd0, 2); set_beats(16'h8000, 3'd0, 1); set_beats(16'h0000, 3'd0, 2);
    pin("rest_model", DEPTH_A, 3, 1'b0, 12'h1E1, 12'hE02, 12'h000);
    run_take(0);

    // Duration saturation, stopped by writing falling
    beat_sw.delete(); beat_band.delete();
    set_beats(16'h0002, 3'd1, 33);
    pin("sat_model", DEPTH_A, 3, 1'b0, 12'h23F, 12'h222, 12'h000);
    run_take(2);

    // Capacity on the 4-deep recorder
    beat_sw.delete(); beat_band.delete();
    for (int i = 0; i < 6; i++) set_beats((i % 2 == 0) ? 16'h0001 : 16'h0002, 3'd0, 1);
    pin("cap_model", DEPTH_B, 4, 1'b1, 12'h001, 12'h021, 12'h001);
    check("cap_model_end", model_words[3], 12'h000);
    run_take(0);

    // Stop coincident with a note-changing tick
    beat_sw.delete(); beat_band.delete();
    set_beats(16'h0001, 3'd0, 2); set_beats(16'h0002, 3'd0, 1);
    pin("coin_model", DEPTH_A, 3, 1'b0, 12'h002, 12'h021, 12'h000);
    run_take(1);
    check("coin_nwrites", wcyc_a.size(), 3);
    if (wcyc_a.size() == 3) begin
      check("coin_change_cyc", wcyc_a[0], stop_cyc);
      check("coin_flush_cyc", wcyc_a[1], stop_cyc + 1);
      check("coin_end_cyc", wcyc_a[2], stop_cyc + 2);
    end

    // Randomized takes
    for (int t = 0; t < 24; t++) begin
      beat_sw.delete(); beat_band.delete();
      nb = $urandom_range(1, 14);
      for (int i = 0; i < nb; i++) begin
        r = $urandom_range(0, 9);
        if (r <= 2) begin
          s = 16'h0000; b = 3'($urandom_range(0, 6));
        end else if (r <= 5 && i > 0) begin
          s = beat_sw[i-1]; b = beat_band[i-1];
        end else if (r <= 7) begin
          s = 16'h0001 << $urandom_range(0, 15); b = 3'($urandom_range(0, 6));
        end else begin
          s = 16'($urandom_range(1, 16'hFFFF)); b = 3'($urandom_range(0, 6));
        end
        beat_sw.push_back(s); beat_band.push_back(b);
      end
      mode = $urandom_range(0, 2);
      run_take(mode);
    end

    // Asynchronous reset in the middle of a take
    quiet = 1'b1;
    @(negedge clk); start_a = 1'b1; start_b = 1'b1;
    @(negedge clk); start_a = 1'b0; start_b = 1'b0;
    sw = 16'h0001; band = 3'd3; repeat (BEAT_DIV) @(negedge clk);
    sw = 16'h0002; repeat (BEAT_DIV) @(negedge clk);
    sw = 16'h0004; repeat (2) @(negedge clk);
    check("midtake_a_rec", rec_a, 1);
    check("midtake_a_count", count_a, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    exp_q_a.delete(); exp_q_b.delete();
    quiet = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3 * BEAT_DIV; i++) begin
      sw = 16'($urandom_range(0, 16'hFFFF));
      @(negedge clk);
    end
    check("post_reset_a_state", 32'(st_a), 32'(IDLE));
    check("post_reset_b_rec", rec_b, 0);
    check("post_reset_a_count", count_a, 0);

    // start while not in writing mode is ignored
    writing = 1'b0;
    @(negedge clk); start_a = 1'b1; start_b = 1'b1;
    @(negedge clk); start_a = 1'b0; start_b = 1'b0;
    repeat (2 * BEAT_DIV) @(negedge clk);
    check("nowrite_a_state", 32'(st_a), 32'(IDLE));
    check("nowrite_b_state", 32'(st_b), 32'(IDLE));
    check("nowrite_a_rec", rec_a, 0);
    writing = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
